prog_truth_lut: RTL and testbench
=================================

Name: prog_truth_lut

Overview:
- Parametrised successor to the fixed 3-input truth-table gate modules; implements any N-input single-output Boolean function.
- The function is held in a runtime-reprogrammable table, loaded serially.
- Evaluation is registered and uses a valid/ready handshake, so the block drops into clocked gate-assignment test harnesses.
- Default parameters reproduce the 0x7B function.

Parameters:
- N_IN, 3, number of Boolean inputs (1..6).
- TABLE, 8'h7B, reset truth table, width 2**N_IN. The MSB is the output for the all-zeros input row and the LSB is the output for the all-ones row (family hex-naming convention).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- cfg_start  input  1  begin table load
- cfg_abort  input  1  discard load in progress
- cfg_bit_valid  input  1  cfg_bit qualifier
- cfg_bit  input  1  serial table bit, MSB (row 0) first
- cfg_busy  output  1  high in LOAD or COMMIT
- cfg_done  output  1  one-cycle pulse when the new table becomes active
- in_valid  input  1  input vector valid
- in_ready  output  1  block can accept a vector
- in_data  input  N_IN  input vector; in_data[N_IN-1] is the first-named input (in1)
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  1  function value

Behaviour:
- Reset (rst high at a clk edge):
  - tbl <= TABLE; shadow <= 0; bit counter <= 0; FSM <= IDLE.
  - out_valid = 0, out_data = 0, cfg_busy = 0, cfg_done = 0.
  - Reset mid-load discards the partial load. tbl reverts to TABLE, not to the last committed table.
- Lookup: f(v) = tbl[2**N_IN-1-v]. Example: TABLE=8'h7B gives f(000)=0, f(101)=0, all other rows 1.
- Config FSM (3 states):
  - IDLE: cfg_start -> LOAD, counter <= 0. cfg_bit_valid is ignored.
  - LOAD: each cfg_bit_valid shifts cfg_bit into the shadow register LSB side, so the first bit ends at the MSB, and increments the counter. When cfg_bit_valid arrives with counter == 2**N_IN-1, go to COMMIT. cfg_start is ignored.
  - LOAD abort: cfg_abort -> IDLE, shadow discarded, tbl unchanged. cfg_abort has priority over a same-cycle cfg_bit_valid.
  - COMMIT: one cycle; tbl <= shadow; cfg_done = 1; -> IDLE. cfg_abort is ignored in COMMIT.
  - cfg_busy = (state != IDLE).
- Evaluation (1-entry output register):
  - in_ready = !out_valid || out_ready (combinational; no dependency on in_valid).
  - Accept when in_valid && in_ready: next edge out_data <= f(in_data), out_valid <= 1. Latency is 1 cycle.
  - out_valid && out_ready with no accept: out_valid <= 0. out_data holds its last value.
  - out_valid && !out_ready: out_data and out_valid are held stable; in_ready = 0.
  - Evaluation continues during LOAD using the old table.
  - Accept in the same cycle as COMMIT uses the pre-commit tbl. The first vector using the new table is accepted in the cycle cfg_done is high or later.
- Throughput: 1 vector/cycle when out_ready is held high.

Decomposition:
- Package prog_truth_lut_pkg:
  - cfg_state_t enum {IDLE, LOAD, COMMIT}.
  - function row_bit(tbl, v) implementing the MSB-first row mapping.
  - localparam helper ROWS(n) = 2**n.
- Sub-module lut_cfg_loader: contains the FSM, counter and shadow; outputs commit strobe and shadow value. The top holds tbl and the eval register.

Test Plan:
- Reset with defaults, sweep in_data 0..7 with out_ready=1 -> out_data sequence 0,1,1,1,1,0,1,1, each 1 cycle after accept; out_valid=0 during reset.
- Load 8'h69 (XOR3): cfg_start, then 8 bits 0,1,1,0,1,0,0,1 -> cfg_done pulses once 1 cycle after the 8th bit; then 3'b111 -> 1, 3'b011 -> 0, 3'b000 -> 0.
- Backpressure: out_ready=0 after accepting 3'b101 -> out_valid=1, out_data=0 held, in_ready=0 for 5 cycles; release -> next vector accepted in the same cycle.
- Abort after 5 bits, same cycle as a cfg_bit_valid -> IDLE, no cfg_done; 3'b000 still -> 0 (0x7B table); a subsequent full load of 8'hFF -> 3'b000 -> 1.
- Eval accept in the COMMIT cycle of an 8'h00 load with in_data=3'b001 -> out_data=1 (old table); next vector 3'b001 -> 0.
- rst asserted after 4 load bits -> cfg_busy=0 next cycle, table = 8'h7B, out_valid=0; N_IN=2, TABLE=4'h6 build: rows 00..11 -> 0,1,1,0.

Source files
------------

// File: rtl/prog_truth_lut_pkg.sv
// Shared types and helpers for the programmable N-input truth-table block.
package prog_truth_lut_pkg;

    localparam int unsigned MAX_ROWS = 64;
    localparam int unsigned IDX_W    = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    // Number of truth-table rows for n inputs.
    function automatic int unsigned rows_of(input int unsigned n);
        return 32'(1) << n;
    endfunction

    // Row 0 (all-zeros input) lives at the MSB of the table, the all-ones row at the LSB.
    function automatic logic row_bit(input logic [MAX_ROWS-1:0] tbl,
                                     input int unsigned rows,
                                     input int unsigned v);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(rows - 32'(1) - v);
        return tbl[idx];
    endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial table loader: collects 2**N_IN bits into a shadow register and strobes commit.
module lut_cfg_loader
    import prog_truth_lut_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    localparam int unsigned ROWS = rows_of(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_abort,
    input  logic            cfg_bit_valid,
    input  logic            cfg_bit,
    output logic            busy_c,
    output logic            commit_c,
    output logic [ROWS-1:0] shadow_q
);

    localparam int unsigned CNT_W = N_IN;

    cfg_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROWS-1:0]  shadow_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        busy_c   = (state_q != IDLE);
        commit_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            LOAD: begin
                // Abort wins over a bit arriving in the same cycle.
                if (cfg_abort) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (cfg_bit_valid) begin
                    shadow_d = {shadow_q[ROWS-2:0], cfg_bit};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ROWS - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                commit_c = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/prog_truth_lut.sv
// Programmable N-input Boolean function with serial table load and a 1-entry
// registered valid/ready evaluation stage.
module prog_truth_lut
    import prog_truth_lut_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    parameter logic [(2**N_IN)-1:0] TABLE = 8'h7B
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_abort,
    input  logic            cfg_bit_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data
);

    localparam int unsigned ROWS = rows_of(N_IN);

    logic [ROWS-1:0] tbl_q, tbl_d;
    logic [ROWS-1:0] shadow;
    logic            busy_c;
    logic            commit_c;
    logic            cfg_done_q, cfg_done_d;
    logic            out_valid_q, out_valid_d;
    logic            out_data_q, out_data_d;
    logic            accept_c;

    lut_cfg_loader #(
        .N_IN (N_IN)
    ) u_loader (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_bit_valid (cfg_bit_valid),
        .cfg_bit       (cfg_bit),
        .busy_c        (busy_c),
        .commit_c      (commit_c),
        .shadow_q      (shadow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_q       <= TABLE;
            cfg_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            cfg_done_q  <= cfg_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Lookup reads tbl_q, so an accept during COMMIT still sees the old table.
    always_comb begin
        tbl_d       = tbl_q;
        cfg_done_d  = commit_c;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        in_ready    = !out_valid_q || out_ready;
        accept_c    = in_valid && in_ready;
        if (commit_c) begin
            tbl_d = shadow;
        end
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = row_bit(MAX_ROWS'(tbl_q), ROWS, 32'(in_data));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign cfg_busy  = busy_c;
    assign cfg_done  = cfg_done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_prog_truth_lut.sv
// Directed bench for prog_truth_lut: default 3-input build plus a 2-input build.
module tb_prog_truth_lut;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, cfg_abort, cfg_bit_valid, cfg_bit;
    logic       cfg_busy, cfg_done;
    logic       in_valid, in_ready, out_valid, out_ready, out_data;
    logic [2:0] in_data;

    logic       cfg_busy2, cfg_done2;
    logic       in_valid2, in_ready2, out_valid2, out_data2;
    logic [1:0] in_data2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_truth_lut u_dut (
        .clk (clk), .rst (rst),
        .cfg_start (cfg_start), .cfg_abort (cfg_abort),
        .cfg_bit_valid (cfg_bit_valid), .cfg_bit (cfg_bit),
        .cfg_busy (cfg_busy), .cfg_done (cfg_done),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data)
    );

    prog_truth_lut #(.N_IN(2), .TABLE(4'h6)) u_dut2 (
        .clk (clk), .rst (rst),
        .cfg_start (1'b0), .cfg_abort (1'b0),
        .cfg_bit_valid (1'b0), .cfg_bit (1'b0),
        .cfg_busy (cfg_busy2), .cfg_done (cfg_done2),
        .in_valid (in_valid2), .in_ready (in_ready2), .in_data (in_data2),
        .out_valid (out_valid2), .out_ready (1'b1), .out_data (out_data2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input logic [2:0] v, input logic exp, input string tag);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(exp));
    endtask

    // Starts a load and shifts all 8 bits; returns in the COMMIT cycle.
    task automatic load_bits(input logic [7:0] t);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = t[7-i];
            tick();
        end
        cfg_bit_valid = 1'b0;
        check("commit_busy", 32'(cfg_busy), 32'd1);
        check("commit_done_lo", 32'(cfg_done), 32'd0);
    endtask

    task automatic finish_load();
        tick();
        check("done_pulse", 32'(cfg_done), 32'd1);
        check("done_busy", 32'(cfg_busy), 32'd0);
        tick();
        check("done_clear", 32'(cfg_done), 32'd0);
    endtask

    initial begin
        logic [7:0] exp7b;
        logic [3:0] exp6;
        exp7b = 8'h7B;
        exp6  = 4'h6;
        rst = 1'b1;
        cfg_start = 1'b0; cfg_abort = 1'b0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        rst = 1'b0;

        // Back-to-back sweep of the reset table, one vector per cycle.
        in_valid = 1'b1;
        for (int v = 0; v < 8; v++) begin
            in_data = 3'(v);
            tick();
            check("sweep_valid", 32'(out_valid), 32'd1);
            check($sformatf("sweep_%0d", v), 32'(out_data), 32'(exp7b[7-v]));
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("hold_data", 32'(out_data), 32'd1);

        // 2-input build with TABLE 4'h6.
        in_valid2 = 1'b1;
        for (int v = 0; v < 4; v++) begin
            in_data2 = 2'(v);
            tick();
            check("n2_valid", 32'(out_valid2), 32'd1);
            check($sformatf("n2_row_%0d", v), 32'(out_data2), 32'(exp6[3-v]));
        end
        in_valid2 = 1'b0;

        // Load XOR3.
        load_bits(8'h69);
        finish_load();
        eval(3'b111, 1'b1, "xor_111");
        eval(3'b011, 1'b0, "xor_011");
        eval(3'b000, 1'b0, "xor_000");
        eval(3'b110, 1'b0, "xor_110");
        tick();

        // Backpressure.
        out_ready = 1'b0;
        eval(3'b101, 1'b0, "bp_accept");
        in_valid = 1'b1;
        in_data  = 3'b111;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data", 32'(out_data), 32'd1);
        tick();

        // Back to the reset table, then abort a load after 5 bits.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'b1;
            tick();
        end
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_bit_valid = 1'b0;
        check("abort_busy", 32'(cfg_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_no_done", 32'(cfg_done), 32'd0);
            tick();
        end
        eval(3'b000, 1'b0, "abort_000");
        eval(3'b101, 1'b0, "abort_101");
        load_bits(8'hFF);
        finish_load();
        eval(3'b000, 1'b1, "ff_000");

        // Accept in the COMMIT cycle of an 8'h00 load sees the old table.
        load_bits(8'h00);
        in_valid = 1'b1;
        in_data  = 3'b001;
        tick();
        check("commit_cycle_done", 32'(cfg_done), 32'd1);
        check("commit_cycle_old", 32'(out_data), 32'd1);
        tick();
        in_valid = 1'b0;
        check("commit_next_new", 32'(out_data), 32'd0);
        tick();

        // Reset in the middle of a load restores the parameter table.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'b0;
            in_valid      = 1'b1;
            in_data       = 3'b010;
            tick();
        end
        cfg_bit_valid = 1'b0;
        in_valid      = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(cfg_busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        eval(3'b001, 1'b1, "midrst_001");
        eval(3'b000, 1'b0, "midrst_000");
        eval(3'b101, 1'b0, "midrst_101");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
